// File: rtl/spi_pkg.sv
// Shared types for the SPI loopback block: FSM state encoding and
// the decode of the SPI mode number into clock polarity and phase.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPHA_DLY,
    P0,
    P1
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;

  function automatic spi_cfg_t mode_cfg(input int unsigned mode);
    spi_cfg_t c;
    c.cpol = mode[1];
    c.cpha = mode[0];
    return c;
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master: half-period divider, four-state phase FSM and MSB-first
// shift registers. One word per transfer; rx_vld pulses when it lands.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned mode  = 3,
  parameter int unsigned dvsr  = 31,
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] din,
  input  logic             tx_vld,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             ss_n,
  output logic             rx_vld,
  output logic [width-1:0] rx_dout,
  output logic [width-1:0] tx_dout
);

  localparam spi_cfg_t    CFG   = mode_cfg(mode);
  localparam int unsigned CNT_W = (dvsr > 0) ? $clog2(dvsr + 1) : 1;
  localparam int unsigned IDX_W = $clog2(width);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(dvsr);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(width - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [width-1:0]   tx_sr_q, tx_sr_d;
  logic [width-1:0]   rx_sr_q, rx_sr_d;
  logic [width-1:0]   rx_dout_q, rx_dout_d;
  logic [width-1:0]   tx_dout_q, tx_dout_d;
  logic               rx_vld_q, rx_vld_d;
  logic               ss_n_q, ss_n_d;
  logic               last_cnt;
  logic               p_clk;

  assign last_cnt = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_dout_q <= '0;
      tx_dout_q <= '0;
      rx_vld_q  <= 1'b0;
      ss_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_dout_q <= rx_dout_d;
      tx_dout_q <= tx_dout_d;
      rx_vld_q  <= rx_vld_d;
      ss_n_q    <= ss_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_dout_d = rx_dout_q;
    tx_dout_d = tx_dout_q;
    rx_vld_d  = 1'b0;
    ss_n_d    = ss_n_q;
    unique case (state_q)
      IDLE: begin
        if (tx_vld) begin
          state_d   = CFG.cpha ? CPHA_DLY : P0;
          tx_sr_d   = din;
          tx_dout_d = din;
          cnt_d     = '0;
          idx_d     = '0;
          ss_n_d    = 1'b0;
        end
      end
      CPHA_DLY: begin
        if (last_cnt) begin
          state_d = P0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      P0: begin
        if (last_cnt) begin
          rx_sr_d = {rx_sr_q[width-2:0], miso};
          state_d = P1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      P1: begin
        if (last_cnt) begin
          cnt_d = '0;
          // rx_sr_q already holds the final bit, sampled at the end of this bit's P0
          if (idx_q == IDX_LAST) begin
            rx_dout_d = rx_sr_q;
            rx_vld_d  = 1'b1;
            ss_n_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            tx_sr_d = {tx_sr_q[width-2:0], 1'b0};
            idx_d   = idx_q + 1'b1;
            state_d = P0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_clk = ((state_q == P1) && !CFG.cpha) || ((state_q == P0) && CFG.cpha);
    sclk  = CFG.cpol ^ p_clk;
  end

  assign mosi    = tx_sr_q[width-1];
  assign ss_n    = ss_n_q;
  assign rx_vld  = rx_vld_q;
  assign rx_dout = rx_dout_q;
  assign tx_dout = tx_dout_q;

endmodule

// File: rtl/spi.sv
// SPI loopback wrapper: the master's serial lines stay internal and
// miso is driven straight from mosi.
module spi
  import spi_pkg::*;
#(
  parameter int unsigned mode  = 3,
  parameter int unsigned dvsr  = 31,
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] din,
  input  logic             tx_vld,
  output logic             rx_vld,
  output logic [width-1:0] rx_dout,
  output logic [width-1:0] tx_dout
);

  logic sclk;
  logic mosi;
  logic miso;
  logic ss_n;
  logic unused_lines;

  assign miso = mosi;
  // sclk and ss_n have no pins; folded here so they remain observable internal nets
  assign unused_lines = sclk ^ ss_n;

  spi_master #(
    .mode (mode),
    .dvsr (dvsr),
    .width(width)
  ) u_master (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .tx_vld (tx_vld),
    .miso   (miso),
    .sclk   (sclk),
    .mosi   (mosi),
    .ss_n   (ss_n),
    .rx_vld (rx_vld),
    .rx_dout(rx_dout),
    .tx_dout(tx_dout)
  );

endmodule

// File: tb/tb_spi.sv
// Scoreboard bench for the SPI loopback: mode 3 / dvsr 31 and mode 0 / dvsr 3
// instances, expected words and rx_vld cycle numbers queued at request time.
module tb_spi;

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  tx;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din, din0;
  logic        tx_vld, tx_vld0;
  logic        rx_vld, rx_vld0;
  logic [7:0]  rx_dout, tx_dout, rx_dout0, tx_dout0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q3[$];
  exp_t        q0[$];

  spi #(.mode(3), .dvsr(31), .width(8)) dut (
    .clk(clk), .rst(rst), .din(din), .tx_vld(tx_vld),
    .rx_vld(rx_vld), .rx_dout(rx_dout), .tx_dout(tx_dout)
  );

  spi #(.mode(0), .dvsr(3), .width(8)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .tx_vld(tx_vld0),
    .rx_vld(rx_vld0), .rx_dout(rx_dout0), .tx_dout(tx_dout0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: every rx_vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rx_vld === 1'b1) begin
      if (q3.size() == 0) begin
        chk("m3_unexpected_rx_vld", {24'h0, rx_dout}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("m3_rx_dout", {24'h0, rx_dout}, {24'h0, e.rx});
        chk("m3_tx_dout", {24'h0, tx_dout}, {24'h0, e.tx});
        chk("m3_rx_vld_cycle", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin
    if (rx_vld0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("m0_unexpected_rx_vld", {24'h0, rx_dout0}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("m0_rx_dout", {24'h0, rx_dout0}, {24'h0, e.rx});
        chk("m0_tx_dout", {24'h0, tx_dout0}, {24'h0, e.tx});
        chk("m0_rx_vld_cycle", cyc, e.at);
      end
    end
  end

  task automatic drain3(input int unsigned budget);
    int unsigned n = 0;
    while (q3.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q3.size() != 0) begin
      chk("m3_timeout_pending", q3.size(), 0);
      q3.delete();
    end
  endtask

  initial begin
    int unsigned bad;
    int unsigned rises;
    int unsigned n;
    logic        prev;
    rst = 1'b1; tx_vld = 1'b0; tx_vld0 = 1'b0; din = '0; din0 = '0;
    repeat (3) @(negedge clk);

    chk("rst_rx_vld",  {31'h0, rx_vld}, 0);
    chk("rst_rx_dout", {24'h0, rx_dout}, 0);
    chk("rst_tx_dout", {24'h0, tx_dout}, 0);
    chk("rst_ss_n",    {31'h0, dut.ss_n}, 1);
    chk("rst_sclk_m3", {31'h0, dut.sclk}, 1);
    chk("rst_sclk_m0", {31'h0, dut0.sclk}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single 0x95, tx_vld for one cycle only, din scribbled afterwards
    din = 8'h95; tx_vld = 1'b1;
    q3.push_back('{rx: 8'h95, tx: 8'h95, at: cyc + 545});
    @(negedge clk);
    tx_vld = 1'b0; din = 8'hFF;
    drain3(1200);
    repeat (5) @(negedge clk);

    // back-to-back with tx_vld held
    din = 8'h95; tx_vld = 1'b1;
    q3.push_back('{rx: 8'h95, tx: 8'h95, at: cyc + 545});
    q3.push_back('{rx: 8'h95, tx: 8'h95, at: cyc + 1090});
    repeat (600) @(negedge clk);
    tx_vld = 1'b0;
    drain3(1200);
    repeat (5) @(negedge clk);

    // din changed mid-transfer
    din = 8'h95; tx_vld = 1'b1;
    q3.push_back('{rx: 8'h95, tx: 8'h95, at: cyc + 545});
    q3.push_back('{rx: 8'h3C, tx: 8'h3C, at: cyc + 1090});
    repeat (100) @(negedge clk);
    din = 8'h3C;
    @(negedge clk);
    chk("mid_tx_dout", {24'h0, tx_dout}, 32'h95);
    chk("mid_ss_n",    {31'h0, dut.ss_n}, 0);
    repeat (500) @(negedge clk);
    tx_vld = 1'b0;
    drain3(1200);
    repeat (5) @(negedge clk);

    // reset mid-transfer: no pulse, everything cleared
    din = 8'h77; tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rx_vld",  {31'h0, rx_vld}, 0);
    chk("abort_rx_dout", {24'h0, rx_dout}, 0);
    chk("abort_tx_dout", {24'h0, tx_dout}, 0);
    chk("abort_ss_n",    {31'h0, dut.ss_n}, 1);
    chk("abort_sclk",    {31'h0, dut.sclk}, 1);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    chk("post_abort_ss_n",    {31'h0, dut.ss_n}, 1);
    chk("post_abort_rx_dout", {24'h0, rx_dout}, 0);

    din = 8'h5A; tx_vld = 1'b1;
    q3.push_back('{rx: 8'h5A, tx: 8'h5A, at: cyc + 545});
    @(negedge clk);
    tx_vld = 1'b0;
    drain3(1200);

    // long idle: lines parked, outputs held
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (dut.sclk !== 1'b1 || dut.ss_n !== 1'b1) bad++;
    end
    chk("idle_lines_bad_cycles", bad, 0);
    chk("hold_rx_dout", {24'h0, rx_dout}, 32'h5A);
    chk("hold_tx_dout", {24'h0, tx_dout}, 32'h5A);

    // mode 0, dvsr 3
    chk("m0_idle_sclk", {31'h0, dut0.sclk}, 0);
    din0 = 8'hA5; tx_vld0 = 1'b1;
    q0.push_back('{rx: 8'hA5, tx: 8'hA5, at: cyc + 65});
    prev = dut0.sclk;
    @(negedge clk);
    tx_vld0 = 1'b0;
    rises = 0; n = 0;
    while (q0.size() != 0 && n < 200) begin
      if (prev == 1'b0 && dut0.sclk == 1'b1) rises++;
      prev = dut0.sclk;
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0) begin
      chk("m0_timeout_pending", q0.size(), 0);
      q0.delete();
    end
    chk("m0_sclk_rises", rises, 8);
    chk("m0_sclk_after", {31'h0, dut0.sclk}, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 SHALL have parameter mode, default 3, meaning SPI mode 0-3 with CPOL=mode[1] and CPHA=mode[0].
REQ-002 SHALL have parameter dvsr, default 31, meaning the SCLK half-period is dvsr+1 clk cycles.
REQ-003 SHALL have parameter width, default 8, meaning the word length in bits (legal range 2..32).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 din  input  width  word to transmit; sampled only when a transfer starts.
REQ-008 tx_vld  input  1  transmit request, level-sensitive; held high means back-to-back transfers.
REQ-009 rx_vld  output  1  one-cycle pulse; rx_dout holds a newly received word.
REQ-010 rx_dout  output  width  last word received on MISO.
REQ-011 tx_dout  output  width  word being or last transmitted (copy of din latched at start).

Function
REQ-012 SHALL contain an SPI master whose serial lines (sclk, mosi, miso, ss_n) are internal, with miso tied to mosi (loopback).
REQ-013 SHALL implement FSM states IDLE, CPHA_DLY, P0, P1 and a phase counter that counts 0..dvsr.
- IDLE -> P0 (CPHA=0) or CPHA_DLY (CPHA=1) when tx_vld=1.
- CPHA_DLY -> P0 after dvsr+1 cycles.
- P0 -> P1 after dvsr+1 cycles.
- P1 -> P0 after dvsr+1 cycles, or P1 -> IDLE on the last bit.
REQ-014 In IDLE with tx_vld=1, SHALL in the same cycle load the tx shift register and tx_dout from din, clear the counter and the bit index, and drive ss_n low.
REQ-015 SHALL transmit MSB first, with mosi = MSB of the tx shift register.
REQ-016 SHALL sample miso into the LSB of the rx shift register (shifting left) on the last cycle of P0.
REQ-017 SHALL shift the tx register left by one on the last cycle of P1 when the bit index < width-1, and then increment the bit index.
REQ-018 On the last cycle of P1 with bit index = width-1, SHALL:
- copy the rx shift register (including the bit sampled this transfer) to rx_dout;
- assert rx_vld for exactly one cycle;
- raise ss_n;
- return to IDLE.
REQ-019 Internal sclk SHALL be CPOL XOR p_clk, where p_clk = 1 in P1 when CPHA=0 and in P0 when CPHA=1; sclk SHALL equal CPOL in IDLE and CPHA_DLY.
REQ-020 Transfer latency from tx_vld accepted in IDLE to the rx_vld pulse SHALL be 2*width*(dvsr+1) cycles, plus dvsr+1 if CPHA=1. For mode 3, dvsr 31, width 8 this is 544 cycles.
REQ-021 With tx_vld still high at the rx_vld cycle, the next transfer SHALL start on the following cycle, with exactly one IDLE cycle between transfers.
REQ-022 Changes on din during a transfer SHALL NOT affect the word in flight or tx_dout.
REQ-023 Dropping tx_vld mid-transfer SHALL NOT abort the transfer.
REQ-024 rx_dout and tx_dout SHALL hold their values between transfers.
REQ-025 After any complete transfer, rx_dout SHALL equal tx_dout.

Reset
REQ-026 While rst=1, SHALL force:
- state to IDLE; counter and bit index to 0;
- shift registers, rx_dout and tx_dout to 0;
- rx_vld to 0, ss_n to 1, sclk to CPOL.
REQ-027 Reset asserted mid-transfer SHALL abort immediately with no rx_vld pulse; after rst falls, a transfer SHALL start only on a tx_vld seen in IDLE.

Structure
REQ-028 Package spi_pkg SHALL hold the FSM state enum and a helper deriving CPOL/CPHA from mode.
REQ-029 Sub-module spi_master SHALL contain the FSM, divider counter and shift registers; spi SHALL wrap it and close the miso=mosi loopback.

Verification
REQ-030 mode 3, dvsr 31, width 8, din 0x95, tx_vld=1 three cycles after reset release -> rx_vld at cycle 544 after acceptance, rx_dout = tx_dout = 0x95.
REQ-031 Same setup with tx_vld held high -> second rx_vld exactly 545 cycles after the first, rx_dout = 0x95 again.
REQ-032 mode 0, dvsr 3, din 0xA5 -> sclk idles low, rx_vld 64 cycles after acceptance, rx_dout = 0xA5.
REQ-033 din changed to 0x3C during a 0x95 transfer -> tx_dout and rx_dout = 0x95; the next transfer carries 0x3C.
REQ-034 rst pulsed mid-transfer -> no rx_vld, all outputs 0; a new 0x5A request then completes correctly.
REQ-035 tx_vld held low for 2000 cycles -> rx_vld never asserts, sclk stays at CPOL, ss_n stays 1.
